pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 120 ++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Stall-aware pipeline stage register: moves one payload between two pipeline
// stages, inserts bubbles, and keeps stall/bubble statistics plus a protocol flag.
module pipe_stage_reg #(
  parameter int DATA_W         = 64,
  parameter int WE_N           = 3,
  parameter int STALL_W        = 6,
  parameter int STAGE          = 3,
  parameter int CNT_W          = 8,
  parameter bit ZERO_ON_BUBBLE = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               cnt_clr,
  input  logic               valid_i,
  input  logic [DATA_W-1:0]  data_i,
  input  logic [WE_N-1:0]    we_i,
  output logic               valid_o,
  output logic [DATA_W-1:0]  data_o,
  output logic [WE_N-1:0]    we_o,
  output logic [CNT_W-1:0]   stall_age_o,
  output logic [CNT_W-1:0]   bubble_cnt_o,
  output logic               proto_err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    M_ADVANCE,
    M_HOLD,
    M_BUBBLE,
    M_FLUSH
  } mode_t;

  logic  s;
  logic  n;
  logic  stall_unused;
  mode_t mode;

  logic              valid_reg;
  logic [DATA_W-1:0] data_reg;
  logic [WE_N-1:0]   we_reg;
  logic [CNT_W-1:0]  age_reg;
  logic [CNT_W-1:0]  bcnt_reg;
  logic              perr_reg;

  assign s = stall[STAGE];
  assign n = stall[STAGE+1];
  // Only two bits of the stall vector matter to this stage.
  assign stall_unused = ^stall;

  always_comb begin
    mode = M_ADVANCE;
    if (flush)
      mode = M_FLUSH;
    else if (s && !n)
      mode = M_BUBBLE;
    else if (s && n)
      mode = M_HOLD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      we_reg    <= '0;
    end else begin
      case (mode)
        M_FLUSH, M_BUBBLE: begin
          valid_reg <= 1'b0;
          we_reg    <= '0;
          if (ZERO_ON_BUBBLE)
            data_reg <= '0;
        end
        M_HOLD: ;
        default: begin
          valid_reg <= valid_i;
          data_reg  <= data_i;
          // Enables of an empty slot must never reach the write-back stage.
          we_reg    <= we_i & {WE_N{valid_i}};
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      age_reg  <= '0;
      bcnt_reg <= '0;
      perr_reg <= 1'b0;
    end else begin
      if (mode == M_HOLD) begin
        if (age_reg != CNT_MAX)
          age_reg <= age_reg + 1'b1;
      end else begin
        age_reg <= '0;
      end

      if (cnt_clr)
        bcnt_reg <= '0;
      else if (mode == M_BUBBLE && bcnt_reg != CNT_MAX)
        bcnt_reg <= bcnt_reg + 1'b1;

      // A set in the same cycle as cnt_clr must not be lost.
      if (!s && n)
        perr_reg <= 1'b1;
      else if (cnt_clr)
        perr_reg <= 1'b0;
    end
  end

  assign valid_o      = valid_reg;
  assign data_o       = data_reg;
  assign we_o         = we_reg;
  assign stall_age_o  = age_reg;
  assign bubble_cnt_o = bcnt_reg;
  assign proto_err_o  = perr_reg;

endmodule
